reset_seq: RTL and testbench

RESET_SEQ -- requirements
Module: reset_seq

---
 rtl/reset_seq_if.sv | 13 +
 rtl/reset_seq.sv | 121 ++++++++++++
 tb/tb_reset_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_if.sv
// Bundle of the reset sequencer's lock/request inputs and staged reset outputs.
interface reset_seq_if #(
  parameter int NUM_OUT = 3
) ();
  logic               pll_lock;
  logic               sw_rst_req;
  logic [NUM_OUT-1:0] rst_out;
  logic               ready;
  logic [7:0]         lock_loss_cnt;

  modport master (output pll_lock, sw_rst_req, input rst_out, ready, lock_loss_cnt);
  modport slave  (input pll_lock, sw_rst_req, output rst_out, ready, lock_loss_cnt);
endinterface

// File: rtl/reset_seq.sv
// Staged reset sequencer: waits for a filtered PLL lock, stretches reset, then
// releases the domain resets one at a time, lowest bit first.
module reset_seq #(
  parameter int NUM_OUT     = 3,
  parameter int LOCK_CYCLES = 256,
  parameter int HOLD_CYCLES = 255,
  parameter int STAGE_GAP   = 16,
  parameter bit USE_LOCK    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  reset_seq_if.slave  sif
);
  localparam int FW = $clog2(LOCK_CYCLES + 1);
  localparam int SW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);

  typedef enum logic [2:0] {HOLD, WAIT_LOCK, COUNT, STAGE, RUN} state_t;

  state_t             r_state, w_state;
  logic [FW-1:0]      r_filt, w_filt;
  logic [SW-1:0]      r_str, w_str;
  logic [GW-1:0]      r_gap, w_gap;
  logic [NUM_OUT-1:0] r_rst, w_rst, w_shift;
  logic               r_ready, w_ready;
  logic [7:0]         r_cnt, w_cnt;
  logic               w_loss, w_sw;

  // Bits release in ascending order, so one release is a left shift of the mask.
  assign w_shift = r_rst << 1;
  assign w_loss  = USE_LOCK && !sif.pll_lock &&
                   (r_state == COUNT || r_state == STAGE || r_state == RUN);
  assign w_sw    = sif.sw_rst_req && (r_state == STAGE || r_state == RUN);

  always_comb begin
    w_state = r_state;
    w_filt  = r_filt;
    w_str   = r_str;
    w_gap   = r_gap;
    w_rst   = r_rst;
    w_ready = r_ready;
    w_cnt   = r_cnt;
    if (w_loss) begin
      w_state = WAIT_LOCK;
      w_filt  = '0;
      w_rst   = '1;
      w_ready = 1'b0;
      if (r_cnt != 8'hFF) w_cnt = r_cnt + 8'd1;
    end else if (w_sw) begin
      w_state = COUNT;
      w_str   = '0;
      w_rst   = '1;
      w_ready = 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          w_filt  = '0;
          w_str   = '0;
          w_state = USE_LOCK ? WAIT_LOCK : COUNT;
        end
        WAIT_LOCK: begin
          if (!sif.pll_lock) begin
            w_filt = '0;
          end else if (r_filt == FW'(LOCK_CYCLES - 1)) begin
            w_state = COUNT;
            w_str   = '0;
            w_filt  = '0;
          end else begin
            w_filt = r_filt + FW'(1);
          end
        end
        COUNT: begin
          if (r_str == SW'(HOLD_CYCLES - 1)) begin
            w_rst   = w_shift;
            w_gap   = '0;
            w_state = (w_shift == '0) ? RUN : STAGE;
            w_ready = (w_shift == '0);
          end else begin
            w_str = r_str + SW'(1);
          end
        end
        STAGE: begin
          if (r_gap == GW'(STAGE_GAP - 1)) begin
            w_rst   = w_shift;
            w_gap   = '0;
            w_state = (w_shift == '0) ? RUN : STAGE;
            w_ready = (w_shift == '0);
          end else begin
            w_gap = r_gap + GW'(1);
          end
        end
        RUN:     ;
        default: w_state = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HOLD;
      r_filt  <= '0;
      r_str   <= '0;
      r_gap   <= '0;
      r_rst   <= '1;
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_filt  <= w_filt;
      r_str   <= w_str;
      r_gap   <= w_gap;
      r_rst   <= w_rst;
      r_ready <= w_ready;
      r_cnt   <= w_cnt;
    end
  end

  assign sif.rst_out       = r_rst;
  assign sif.ready         = r_ready;
  assign sif.lock_loss_cnt = r_cnt;
endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: vector table, directed corner sequences and a random run
// scored against a timeline model (edges since lock acceptance).
module tb_reset_seq;
  localparam int N = 3, L = 4, H = 8, G = 2;
  localparam int DONE = H + (N - 1) * G;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reset_seq_if #(.NUM_OUT(N)) sif ();
  reset_seq_if #(.NUM_OUT(N)) sif0 ();

  reset_seq #(.NUM_OUT(N), .LOCK_CYCLES(L), .HOLD_CYCLES(H), .STAGE_GAP(G), .USE_LOCK(1'b1))
    dut (.clk(clk), .reset(reset), .sif(sif));
  reset_seq #(.NUM_OUT(N), .LOCK_CYCLES(L), .HOLD_CYCLES(H), .STAGE_GAP(G), .USE_LOCK(1'b0))
    dut0 (.clk(clk), .reset(reset), .sif(sif0));

  int n_pass = 0, n_tot = 0;

  // Model: phase 0 = post-reset hold, 1 = waiting for lock, 2 = sequencing,
  // where m_t counts edges since lock was accepted or soft reset restarted.
  int m_phase = 0, m_t = 0, m_cons = 0, m_cnt = 0;

  task automatic model_edge(input bit r, input bit lk, input bit sw);
    if (r) begin
      m_phase = 0; m_t = 0; m_cons = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_cons = 0;
    end else if (m_phase == 1) begin
      if (lk) begin
        m_cons++;
        if (m_cons == L) begin m_phase = 2; m_t = 0; end
      end else m_cons = 0;
    end else begin
      if (!lk) begin
        m_phase = 1; m_cons = 0;
        if (m_cnt < 255) m_cnt++;
      end else if (sw && m_t >= H) m_t = 0;
      else if (m_t < DONE) m_t++;
    end
  endtask

  function automatic int m_rst();
    int v = 0;
    for (int k = 0; k < N; k++)
      if (m_phase != 2 || m_t < H + k * G) v |= (1 << k);
    return v;
  endfunction

  task automatic step(input int n);
    bit r, lk, sw;
    repeat (n) begin
      r = reset; lk = sif.pll_lock; sw = sif.sw_rst_req;
      @(posedge clk);
      model_edge(r, lk, sw);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk3(input string name, input int rst, input int rdy, input int cnt);
    chk({name, ".rst_out"}, int'(sif.rst_out), rst);
    chk({name, ".ready"}, int'(sif.ready), rdy);
    chk({name, ".lock_loss_cnt"}, int'(sif.lock_loss_cnt), cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1; sif.pll_lock = 1'b0; sif.sw_rst_req = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  typedef struct {
    int       n;
    bit       lock;
    bit       sw;
    int       rst;
    int       rdy;
    int       cnt;
    string    name;
  } vec_t;

  function automatic vec_t mk(int n, bit lock, bit sw, int rst, int rdy, int cnt, string name);
    vec_t v;
    v.n = n; v.lock = lock; v.sw = sw; v.rst = rst; v.rdy = rdy; v.cnt = cnt; v.name = name;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Edge counts are relative to the previous entry; comments give absolute edges.
    tbl.push_back(mk(1, 1, 0, 7, 0, 0, "hold_exit"));        // 1
    tbl.push_back(mk(4, 1, 0, 7, 0, 0, "lock_accept"));      // 5
    tbl.push_back(mk(7, 1, 0, 7, 0, 0, "count_last"));       // 12
    tbl.push_back(mk(1, 1, 0, 6, 0, 0, "rel0"));             // 13
    tbl.push_back(mk(1, 1, 0, 6, 0, 0, "gap0"));             // 14
    tbl.push_back(mk(1, 1, 0, 4, 0, 0, "rel1"));             // 15
    tbl.push_back(mk(1, 1, 0, 4, 0, 0, "gap1"));             // 16
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, "run"));              // 17
    tbl.push_back(mk(3, 1, 0, 0, 1, 0, "run_stay"));
    tbl.push_back(mk(1, 0, 0, 7, 0, 1, "lock_drop"));        // E
    tbl.push_back(mk(1, 0, 0, 7, 0, 1, "wait_low"));         // E+1
    tbl.push_back(mk(14, 1, 0, 4, 0, 1, "relock_rel1"));     // E+15
    tbl.push_back(mk(1, 1, 0, 4, 0, 1, "relock_pre"));       // E+16
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, "relock_run"));       // E+17
    tbl.push_back(mk(1, 1, 1, 7, 0, 1, "sw_req"));           // R
    tbl.push_back(mk(7, 1, 0, 7, 0, 1, "sw_count"));         // R+7
    tbl.push_back(mk(1, 1, 0, 6, 0, 1, "sw_rel0"));          // R+8
    tbl.push_back(mk(3, 1, 0, 4, 0, 1, "sw_rel1"));          // R+11
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, "sw_run"));           // R+12
    tbl.push_back(mk(1, 0, 1, 7, 0, 2, "loss_with_sw"));     // E
    tbl.push_back(mk(1, 1, 1, 7, 0, 2, "sw_in_wait"));       // E+1
    tbl.push_back(mk(3, 1, 0, 7, 0, 2, "relock2"));          // E+4 (COUNT)
    tbl.push_back(mk(1, 1, 1, 7, 0, 2, "sw_in_count"));      // E+5
    tbl.push_back(mk(6, 1, 0, 7, 0, 2, "count2_last"));      // E+11
    tbl.push_back(mk(1, 1, 0, 6, 0, 2, "count2_rel0"));      // E+12

    sif.pll_lock = 1'b0; sif.sw_rst_req = 1'b0;
    sif0.pll_lock = 1'b0; sif0.sw_rst_req = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk3("reset", 7, 0, 0);
    chk("reset.dut0_rst", int'(sif0.rst_out), 7);
    chk("reset.dut0_ready", int'(sif0.ready), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      sif.pll_lock = tbl[i].lock; sif.sw_rst_req = tbl[i].sw;
      step(tbl[i].n);
      chk3(tbl[i].name, tbl[i].rst, tbl[i].rdy, tbl[i].cnt);
    end
    sif.sw_rst_req = 1'b0;

    // USE_LOCK=0 instance ignores pll_lock entirely.
    do_reset();
    step(9);
    chk("nolock.e9_rst", int'(sif0.rst_out), 6);
    step(3);
    chk("nolock.e12_rst", int'(sif0.rst_out), 4);
    chk("nolock.e12_ready", int'(sif0.ready), 0);
    step(1);
    chk("nolock.e13_rst", int'(sif0.rst_out), 0);
    chk("nolock.e13_ready", int'(sif0.ready), 1);

    // One-cycle lock glitch restarts the filter.
    do_reset();
    sif.pll_lock = 1'b1; step(2);
    sif.pll_lock = 1'b0; step(1);
    sif.pll_lock = 1'b1; step(11);
    chk3("glitch.e14", 7, 0, 0);
    step(1);
    chk3("glitch.e15", 6, 0, 0);
    step(3);
    chk3("glitch.e18", 4, 0, 0);
    step(1);
    chk3("glitch.e19", 0, 1, 0);

    // Reset in STAGE after a lock loss clears the loss count and restarts timing.
    do_reset();
    sif.pll_lock = 1'b1; step(17);
    sif.pll_lock = 1'b0; step(1);
    sif.pll_lock = 1'b1; step(12);
    chk3("midrst.stage", 6, 0, 1);
    reset = 1'b1; step(1); reset = 1'b0;
    chk3("midrst.after", 7, 0, 0);
    step(16);
    chk3("midrst.e16", 4, 0, 0);
    step(1);
    chk3("midrst.e17", 0, 1, 0);

    // 257 lock-loss events, each taken from COUNT.
    do_reset();
    sif.pll_lock = 1'b1; step(5);
    for (int i = 0; i < 257; i++) begin
      sif.pll_lock = 1'b0; step(1);
      if (i == 253) chk("sat.254", int'(sif.lock_loss_cnt), 254);
      sif.pll_lock = 1'b1; step(4);
    end
    chk("sat.final", int'(sif.lock_loss_cnt), 255);

    // Random run scored against the timeline model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sif.pll_lock   = ($urandom_range(0, 99) >= 4);
      sif.sw_rst_req = ($urandom_range(0, 99) < 4);
      reset          = ($urandom_range(0, 499) == 0);
      step(1);
      chk("rand.rst_out", int'(sif.rst_out), m_rst());
      chk("rand.ready", int'(sif.ready), (m_phase == 2 && m_t >= DONE) ? 1 : 0);
      chk("rand.lock_loss_cnt", int'(sif.lock_loss_cnt), m_cnt);
      if (sif.ready && sif.rst_out != '0) chk("rand.ready_excl", 1, 0);
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
